uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Parametrised, runtime-configurable UART transmitter with an integrated transmit FIFO and valid/ready input. It is the next-generation replacement for the fixed 8N1 transmitter. It sits between the crypto result path (AES/RSA output bytes) and the board TX pin. It serialises queued bytes back-to-back with no idle gap and applies per-frame data length, parity and stop-bit settings.

## Interface
- FIFO_DEPTH, 16: transmit FIFO entries; power of two, ≥2.
- DIV_W, 16: width of the runtime baud divisor.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  8  byte to queue; bits above the configured data length are ignored.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full; a byte is accepted on a rising edge with s_valid && s_ready.
- cfg_div  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2.
- cfg_data_bits  in  2  data length: 00=5, 01=6, 10=7, 11=8.
- cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none.
- cfg_stop2  in  1  0=one stop bit, 1=two stop bits.
- tx_serial  out  1  UART line; idle high.
- tx_busy  out  1  a frame is in progress (state ≠ IDLE).
- tx_done  out  1  one-cycle pulse on completion of each frame.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

## Operation
- FIFO: circular buffer with read/write pointers and a registered count.
  - Push when s_valid && s_ready.
  - Pop when the engine loads a frame.
  - Simultaneous push and pop leaves the count unchanged.
  - s_ready = (fifo_count != FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
- Engine states: IDLE, START, DATA, PARITY, STOP.
- Frame load (pop):
  - Triggered in IDLE when the FIFO is non-empty, or on the final cycle of STOP when the FIFO is non-empty.
  - On load, the engine latches the byte, cfg_div (clamped), cfg_data_bits, cfg_parity and cfg_stop2 into frame registers.
  - Config changes mid-frame have no effect until the next load.
- IDLE: tx_serial=1. On load → START.
- START: tx_serial=0 for div cycles → DATA.
- DATA: bits sent LSB first, N bits (N = 5..8), each held for div cycles.
  - After bit N-1 → PARITY if parity is enabled, else → STOP.
- PARITY: tx_serial = XOR of the N data bits for even parity, or its inverse for odd parity; held for div cycles → STOP.
- STOP: tx_serial=1 for div cycles, or 2·div cycles when cfg_stop2=1.
  - On the final cycle, pulse tx_done.
  - Then → START with a new load if the FIFO is non-empty, else → IDLE.
- Bit counter: 3-bit index.
- Baud counter: DIV_W bits, counting 0..div-1. Terminal count is div-1; no off-by-one is permitted.

## Timing
- Reset values (asynchronous, applied immediately, including mid-frame):
  - tx_serial=1, tx_busy=0, tx_done=0, fifo_count=0, s_ready=1.
  - FIFO flushed; state IDLE.
- tx_serial, tx_busy and tx_done are registered outputs.
- Latency: a byte accepted into an empty FIFO at edge E0 is popped at edge E1; tx_serial falls after E1 and tx_busy rises after E1.
- Frame duration: exactly div·(1+N+P+S) cycles, with P∈{0,1} and S∈{1,2}.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, with no idle cycle between frames.
- tx_done pulses high for exactly one cycle, aligned to the last stop-bit cycle.
- fifo_count reflects a push or pop on the cycle after the accepting edge.
- A full FIFO holds s_ready low. A pop while s_valid is held frees a slot, and the push is accepted on the following edge.

## Test plan
- Single 8N1 byte:
  - Stimulus: cfg_div=4, byte 0xA5.
  - Required: line 0, then bits 1,0,1,0,0,1,0,1, then 1; each bit exactly 4 cycles; total 40 cycles; one tx_done pulse; tx_busy low after.
- 7E2 / 5O1 parity:
  - 0x53 with 7 data bits, even parity, 2 stop bits gives parity bit 0 and a 44-cycle frame at div=4.
  - 0x1F with 5 data bits, odd parity gives parity bit 0.
- FIFO fill:
  - Push 17 bytes at depth 16 while the line is busy.
  - Required: s_ready drops when fifo_count=16; all bytes are transmitted in order with zero gap between frames; 17 tx_done pulses.
- Config change mid-frame:
  - Change cfg_div 4→8 during bit 3.
  - Required: the current frame stays at 4 cycles/bit; the next frame uses 8.
- Reset mid-frame plus divisor clamp:
  - Assert rst_n low during DATA with 3 bytes queued.
  - Required: tx_serial=1 immediately and fifo_count=0; after release the line stays idle.
  - Then with cfg_div=0, every bit lasts 2 cycles.

Source files
------------

// File: rtl/uart_tx_stream.sv
// UART transmitter with an integrated transmit FIFO and a valid/ready byte input.
// Each frame latches its own data length, parity, stop bits and divisor, and frames are sent back-to-back.
module uart_tx_stream #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------- transmit FIFO ----------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_load;
  logic          w_empty;
  logic [7:0]    w_load_data;

  assign s_ready    = (r_count != FULL_CNT);
  assign fifo_count = r_count;
  assign w_push     = s_valid && s_ready;
  assign w_empty    = (r_count == '0);
  // Bits above the configured length are cleared so the parity reduction can use the whole byte.
  assign w_load_data = r_mem[r_rd_ptr] & (8'hFF >> (2'd3 - cfg_data_bits));

  // NOTE: storage array has no reset; only pointers and count carry state that matters after reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- frame engine ----------------
  state_t           r_state;
  logic [DIV_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic             r_stop_idx;
  logic [7:0]       r_shift;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_last_bit;
  logic             r_par_en;
  logic             r_par_odd;
  logic             r_stop2;
  logic             r_tx_serial;
  logic             r_tx_busy;
  logic             r_tx_done;

  state_t           w_nxt_state;
  logic [DIV_W-1:0] w_nxt_baud;
  logic [2:0]       w_nxt_bit;
  logic             w_nxt_stop;
  logic             w_nxt_serial;
  logic             w_nxt_done;
  logic             w_tick;
  logic [DIV_W-1:0] w_div_clamped;

  assign w_tick        = (r_baud == r_div - 1'b1);
  assign w_div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_baud  = r_baud + 1'b1;
    w_nxt_bit   = r_bit_idx;
    w_nxt_stop  = r_stop_idx;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_nxt_baud = '0;
        if (!w_empty) begin
          w_load      = 1'b1;
          w_nxt_state = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_nxt_baud  = '0;
          w_nxt_bit   = '0;
          w_nxt_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_nxt_baud = '0;
          if (r_bit_idx == r_last_bit) begin
            w_nxt_stop  = 1'b0;
            w_nxt_state = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_nxt_bit = r_bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_nxt_baud  = '0;
          w_nxt_stop  = 1'b0;
          w_nxt_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_nxt_baud = '0;
          if (r_stop_idx == r_stop2) begin
            if (!w_empty) begin
              w_load      = 1'b1;
              w_nxt_state = ST_START;
            end else begin
              w_nxt_state = ST_IDLE;
            end
          end else begin
            w_nxt_stop = 1'b1;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    w_nxt_serial = 1'b1;
    unique case (w_nxt_state)
      ST_START:  w_nxt_serial = 1'b0;
      ST_DATA:   w_nxt_serial = r_shift[w_nxt_bit];
      ST_PARITY: w_nxt_serial = (^r_shift) ^ r_par_odd;
      default:   w_nxt_serial = 1'b1;
    endcase
    w_nxt_done = (w_nxt_state == ST_STOP) && (w_nxt_baud == r_div - 1'b1) &&
                 (w_nxt_stop == r_stop2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_div       <= DIV_W'(2);
      r_last_bit  <= 3'd7;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_tx_serial <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_baud      <= w_nxt_baud;
      r_bit_idx   <= w_nxt_bit;
      r_stop_idx  <= w_nxt_stop;
      r_tx_serial <= w_nxt_serial;
      r_tx_busy   <= (w_nxt_state != ST_IDLE);
      r_tx_done   <= w_nxt_done;
      if (w_load) begin
        r_shift    <= w_load_data;
        r_div      <= w_div_clamped;
        r_last_bit <= {1'b1, cfg_data_bits};
        r_par_en   <= cfg_parity[0] ^ cfg_parity[1];
        r_par_odd  <= cfg_parity[1] & ~cfg_parity[0];
        r_stop2    <= cfg_stop2;
      end
    end
  end

  assign tx_serial = r_tx_serial;
  assign tx_busy   = r_tx_busy;
  assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: directed scenarios plus random batches, with a per-cycle line model
// built from each queued byte and the configuration in force when it was queued.
module tb_uart_tx_stream;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_data_bits;
  logic [1:0]       cfg_parity;
  logic             cfg_stop2;
  logic             tx_serial;
  logic             tx_busy;
  logic             tx_done;
  logic [CW-1:0]    fifo_count;

  uart_tx_stream #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_serial     (tx_serial),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         par;    // 1 even, 2 odd, otherwise none
    int         stops;
    int         div;
  } frame_t;

  frame_t frames [0:511];
  int     wr_n = 0;
  int     rd_n = 0;
  bit     ln_q [$];
  bit     dn_q [$];
  bit     in_frame = 1'b0;
  int     wait_cnt = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_done   = 0;
  logic   cap [0:2047];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d);
    frame_t f;
    f.data  = d;
    f.nbits = int'(cfg_data_bits) + 5;
    f.par   = int'(cfg_parity);
    f.stops = cfg_stop2 ? 2 : 1;
    f.div   = (cfg_div < 2) ? 2 : int'(cfg_div);
    return f;
  endfunction

  // Expected line level and tx_done for every cycle of one frame.
  task automatic expand(input frame_t f);
    bit p;
    bit v;
    p = 1'b0;
    for (int i = 0; i < f.div; i++) begin ln_q.push_back(1'b0); dn_q.push_back(1'b0); end
    for (int b = 0; b < f.nbits; b++) begin
      v = f.data[b];
      p = p ^ v;
      for (int i = 0; i < f.div; i++) begin ln_q.push_back(v); dn_q.push_back(1'b0); end
    end
    if (f.par == 1 || f.par == 2) begin
      v = (f.par == 2) ? ~p : p;
      for (int i = 0; i < f.div; i++) begin ln_q.push_back(v); dn_q.push_back(1'b0); end
    end
    for (int i = 0; i < f.stops * f.div; i++) begin
      ln_q.push_back(1'b1);
      dn_q.push_back(i == f.stops * f.div - 1);
    end
  endtask

  // Per-cycle line check: a queued byte starts exactly two edges after acceptance into an
  // idle transmitter, or immediately after the previous frame's last stop cycle.
  task automatic mon();
    if (ln_q.size() == 0 && rd_n != wr_n) begin
      if (in_frame || wait_cnt == 1) begin
        expand(frames[rd_n]);
        rd_n++;
        wait_cnt = 0;
      end else begin
        wait_cnt = 1;
      end
    end
    if (ln_q.size() != 0) begin
      check("mon_line", tx_serial, ln_q.pop_front());
      check("mon_done", tx_done, dn_q.pop_front());
      check("mon_busy", tx_busy, 1);
      in_frame = 1'b1;
    end else begin
      check("mon_idle_line", tx_serial, 1);
      check("mon_idle_done", tx_done, 0);
      check("mon_idle_busy", tx_busy, 0);
      in_frame = 1'b0;
    end
    if (tx_done === 1'b1) n_done++;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    acc     = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int k = 0; k < 4000 && !acc; k++) begin
      if (s_ready) begin
        acc = 1'b1;
        frames[wr_n] = make_frame(d);
        wr_n++;
      end
      step();
    end
    s_valid = 1'b0;
    check("push_accepted", acc, 1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20000; k++) begin
      if (ln_q.size() == 0 && rd_n == wr_n && tx_busy === 1'b0 && fifo_count == 0) break;
      step();
    end
    check("wait_idle_bound", k < 20000, 1);
  endtask

  // Sends one byte into an idle transmitter, checks latency, captures the frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] nb,
                           input logic [1:0] par, input logic st2, input logic [DIV_W-1:0] div,
                           input int exp_len);
    int d0;
    int len;
    wait_idle();
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = st2;
    cfg_div       = div;
    d0 = n_done;
    push(d);
    check({tag, "_e0_count"}, fifo_count, 1);
    check({tag, "_e0_line"}, tx_serial, 1);
    check({tag, "_e0_busy"}, tx_busy, 0);
    step();
    check({tag, "_e1_count"}, fifo_count, 0);
    check({tag, "_e1_line"}, tx_serial, 0);
    check({tag, "_e1_busy"}, tx_busy, 1);
    cap[0] = tx_serial;
    len = 1;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (tx_busy !== 1'b1) break;
      cap[len] = tx_serial;
      len++;
    end
    check({tag, "_frame_len"}, len, exp_len);
    check({tag, "_done_pulses"}, n_done - d0, 1);
    check({tag, "_busy_after"}, tx_busy, 0);
  endtask

  initial begin
    logic [9:0] pat;
    int         d0;

    rst_n         = 1'b1;
    s_data        = '0;
    s_valid       = 1'b0;
    cfg_div       = DIV_W'(4);
    cfg_data_bits = 2'b11;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_line", tx_serial, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ready", s_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();

    // 8N1 0xA5 at div 4: start, LSB-first data, stop; 4 cycles per bit
    run_frame("8n1", 8'hA5, 2'b11, 2'b00, 1'b0, DIV_W'(4), 40);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < 4; c++)
        check($sformatf("8n1_bit%0d_c%0d", i, c), cap[i*4 + c], pat[i]);

    // 7E2 0x53: parity bit 0, 44 cycles
    run_frame("7e2", 8'h53, 2'b10, 2'b01, 1'b1, DIV_W'(4), 44);
    check("7e2_parity", cap[33], 0);

    // 5O1 0x1F: parity bit 0, 32 cycles
    run_frame("5o1", 8'h1F, 2'b00, 2'b10, 1'b0, DIV_W'(4), 32);
    check("5o1_parity", cap[25], 0);

    // FIFO fill: 17 pushes while busy fill the FIFO; an 18th is held until a pop
    wait_idle();
    cfg_div = DIV_W'(4); cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
    check("fill_count", fifo_count, 16);
    check("fill_ready_low", s_ready, 0);
    check("fill_busy", tx_busy, 1);
    push(8'hEE);
    check("fill_refill_count", fifo_count, 16);
    wait_idle();
    check("fill_done_pulses", n_done - d0, 18);

    // Divisor change during bit 3 only affects the following frame
    wait_idle();
    cfg_div = DIV_W'(4);
    push(8'h3C);
    repeat (19) step();
    check("cfgchg_busy", tx_busy, 1);
    cfg_div = DIV_W'(8);
    push(8'hC3);
    wait_idle();

    // Reset during DATA with bytes queued
    cfg_div = DIV_W'(4);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (8) step();
    check("rst_pre_busy", tx_busy, 1);
    check("rst_pre_count", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_line", tx_serial, 1);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_ready", s_ready, 1);
    rd_n = wr_n;
    ln_q.delete();
    dn_q.delete();
    in_frame = 1'b0;
    wait_cnt = 0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("rst_after_line", tx_serial, 1);
    check("rst_after_count", fifo_count, 0);

    // Divisor 0 behaves as 2
    run_frame("clamp", 8'h5B, 2'b11, 2'b00, 1'b0, DIV_W'(0), 20);
    check("clamp_start_c1", cap[1], 0);
    check("clamp_bit0_c0", cap[2], 1);

    // Random batches: configuration held per batch, bytes queued back to back
    for (int b = 0; b < 12; b++) begin
      int nb;
      wait_idle();
      cfg_div       = DIV_W'($urandom_range(0, 5));
      cfg_data_bits = 2'($urandom_range(0, 3));
      cfg_parity    = 2'($urandom_range(0, 3));
      cfg_stop2     = 1'($urandom_range(0, 1));
      nb = int'($urandom_range(1, 4));
      for (int i = 0; i < nb; i++) push(8'($urandom_range(0, 255)));
    end
    wait_idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
